// File: rtl/csr_trap_ctrl_if.sv
// Bundle of pipeline, interrupt and csr-port signals around csr_trap_ctrl.
interface csr_trap_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              instr_csr_req;
    logic [CSR_AW-1:0] instr_csr_addr;
    logic [XLEN-1:0]   instr_csr_wdata;
    logic              instr_csr_gnt;
    logic              exc_req;
    logic [4:0]        exc_cause;
    logic [XLEN-1:0]   exc_tval;
    logic [XLEN-1:0]   trap_pc;
    logic              mret_req;
    logic [2:0]        irq_pending;
    logic [2:0]        mie_en;
    logic [XLEN-1:0]   mstatus;
    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mepc;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              stall;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output instr_csr_req, instr_csr_addr, instr_csr_wdata,
        output exc_req, exc_cause, exc_tval, trap_pc, mret_req,
        output irq_pending, mie_en, mstatus, mtvec, mepc,
        input  instr_csr_gnt, csr_we, csr_waddr, csr_wdata,
        input  stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  instr_csr_req, instr_csr_addr, instr_csr_wdata,
        input  exc_req, exc_cause, exc_tval, trap_pc, mret_req,
        input  irq_pending, mie_en, mstatus, mtvec, mepc,
        output instr_csr_gnt, csr_we, csr_waddr, csr_wdata,
        output stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer that owns the single csr write port.
// Optional macro CSR_TRAP_VECTORED_EN: vectored interrupt targets when mtvec.MODE==1.
module csr_trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic           clk,
    input  logic           rst,
    csr_trap_ctrl_if.slave bus
);
    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] ADDR_MTVAL   = CSR_AW'(12'h343);

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_STAT, REDIR
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_epc;
    logic            r_isMret;

    logic [2:0]      w_irqActive;
    logic            w_irqTake;
    logic            w_idle;
    logic            w_trapAcc;
    logic            w_mretAcc;
    logic            w_instrGnt;
    logic [4:0]      w_irqCode;
    logic [XLEN-1:0] w_trapStat;
    logic [XLEN-1:0] w_mretStat;
    logic [XLEN-1:0] w_trapBase;
    logic [XLEN-1:0] w_trapTarget;

    assign w_irqActive = bus.irq_pending & bus.mie_en;
    assign w_irqTake   = (|w_irqActive) & bus.mstatus[3];
    assign w_idle      = (r_state == IDLE);
    assign w_trapAcc   = w_idle & (bus.exc_req | w_irqTake);
    assign w_mretAcc   = w_idle & ~bus.exc_req & ~w_irqTake & bus.mret_req;
    assign w_instrGnt  = w_idle & ~w_trapAcc & ~w_mretAcc & bus.instr_csr_req & ~rst;
    assign w_trapBase  = bus.mtvec & ~XLEN'(3);

    // Interrupt priority is external > software > timer, not bit order.
    always_comb begin
        w_irqCode = 5'd0;
        if (w_irqActive[2]) begin
            w_irqCode = 5'd11;
        end else if (w_irqActive[0]) begin
            w_irqCode = 5'd3;
        end else if (w_irqActive[1]) begin
            w_irqCode = 5'd7;
        end
    end

    always_comb begin
        w_trapStat        = bus.mstatus;
        w_trapStat[7]     = bus.mstatus[3];
        w_trapStat[3]     = 1'b0;
        w_trapStat[12:11] = 2'b11;
        w_mretStat        = bus.mstatus;
        w_mretStat[3]     = bus.mstatus[7];
        w_mretStat[7]     = 1'b1;
        w_mretStat[12:11] = 2'b11;
    end

`ifdef CSR_TRAP_VECTORED_EN
    assign w_trapTarget = (bus.mtvec[1:0] == 2'b01 && r_cause[XLEN-1])
                        ? w_trapBase + XLEN'({r_cause[4:0], 2'b00})
                        : w_trapBase;
`else
    assign w_trapTarget = w_trapBase;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cause  <= '0;
            r_tval   <= '0;
            r_epc    <= '0;
            r_isMret <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trapAcc) begin
                        r_state  <= T_EPC;
                        r_isMret <= 1'b0;
                        r_epc    <= bus.trap_pc & ~XLEN'(3);
                        if (bus.exc_req) begin
                            r_cause <= XLEN'(bus.exc_cause);
                            r_tval  <= bus.exc_tval;
                        end else begin
                            r_cause <= {1'b1, {(XLEN-6){1'b0}}, w_irqCode};
                            r_tval  <= '0;
                        end
                    end else if (w_mretAcc) begin
                        r_state  <= M_STAT;
                        r_isMret <= 1'b1;
                    end
                end
                T_EPC:   r_state <= T_CAUSE;
                T_CAUSE: r_state <= T_TVAL;
                T_TVAL:  r_state <= T_STAT;
                T_STAT:  r_state <= REDIR;
                M_STAT:  r_state <= REDIR;
                REDIR:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Port mux: pipeline passthrough only in IDLE, sequence writes decoded from state.
    always_comb begin
        bus.instr_csr_gnt  = 1'b0;
        bus.csr_we         = 1'b0;
        bus.csr_waddr      = '0;
        bus.csr_wdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = (~w_idle | w_trapAcc | w_mretAcc) & ~rst;
        case (r_state)
            IDLE: begin
                if (w_instrGnt) begin
                    bus.instr_csr_gnt = 1'b1;
                    bus.csr_we        = 1'b1;
                    bus.csr_waddr     = bus.instr_csr_addr;
                    bus.csr_wdata     = bus.instr_csr_wdata;
                end
            end
            T_EPC: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = ADDR_MEPC;
                bus.csr_wdata = r_epc;
            end
            T_CAUSE: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = ADDR_MCAUSE;
                bus.csr_wdata = r_cause;
            end
            T_TVAL: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = ADDR_MTVAL;
                bus.csr_wdata = r_tval;
            end
            T_STAT: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = ADDR_MSTATUS;
                bus.csr_wdata = w_trapStat;
            end
            M_STAT: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = ADDR_MSTATUS;
                bus.csr_wdata = w_mretStat;
            end
            REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_isMret ? bus.mepc : w_trapTarget;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: directed and random transactions checked
// against a transaction-level model of trap entry, MRET and CSR passthrough.
module tb_csr_trap_ctrl;
    typedef struct {
        int          cyc;
        bit          isRedir;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;
    bit   expGnt = 1'b0;
    bit   expStall = 1'b0;
    bit   monOn = 1'b0;
    exp_t sbq[$];

    csr_trap_ctrl_if #(.XLEN(32), .CSR_AW(12)) bus();

    csr_trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void pushExp(input int c, input bit r, input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc     = c;
        e.isRedir = r;
        e.addr    = a;
        e.data    = d;
        sbq.push_back(e);
    endfunction

    // Monitor: compares every presented write/redirect against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            checkOutput("stall", bus.stall, expStall);
            checkOutput("gnt", bus.instr_csr_gnt, expGnt);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                nTests++;
                nFail++;
                $display("[TB] FAIL missing cyc=%0d got=none exp=redir%0b/%0h/%0h", e.cyc, e.isRedir, e.addr, e.data);
            end
            if (bus.csr_we || bus.redirect_valid) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                    nTests++;
                    nFail++;
                    $display("[TB] FAIL unexpected cyc=%0d got=we%0b/rv%0b addr=%0h data=%0h pc=%0h exp=none",
                             cyc, bus.csr_we, bus.redirect_valid, bus.csr_waddr, bus.csr_wdata, bus.redirect_pc);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("redirect_valid", bus.redirect_valid, e.isRedir);
                    checkOutput("csr_we", bus.csr_we, !e.isRedir);
                    if (e.isRedir) begin
                        checkOutput("redirect_pc", bus.redirect_pc, e.data);
                    end else begin
                        checkOutput("csr_waddr", bus.csr_waddr, e.addr);
                        checkOutput("csr_wdata", bus.csr_wdata, e.data);
                    end
                end
            end
        end
    end

    // Drives one IDLE-cycle request set and records what the model says must follow.
    task automatic applyStimulus(
        input bit exc, input bit mret, input bit req,
        input logic [2:0] pend, input logic [2:0] en,
        input logic [31:0] stat, input logic [31:0] tvec, input logic [31:0] epc,
        input logic [31:0] tpc, input logic [31:0] tval, input logic [4:0] cause,
        input logic [11:0] addr, input logic [31:0] wdata, output int busy);
        int          t;
        int          code;
        int          prioBit[3];
        int          prioCode[3];
        bit          irq;
        logic [31:0] s;
        logic [31:0] tgt;
        prioBit  = '{2, 0, 1};
        prioCode = '{11, 3, 7};
        bus.exc_req         = exc;
        bus.mret_req        = mret;
        bus.instr_csr_req   = req;
        bus.irq_pending     = pend;
        bus.mie_en          = en;
        bus.mstatus         = stat;
        bus.mtvec           = tvec;
        bus.mepc            = epc;
        bus.trap_pc         = tpc;
        bus.exc_tval        = tval;
        bus.exc_cause       = cause;
        bus.instr_csr_addr  = addr;
        bus.instr_csr_wdata = wdata;
        t    = cyc;
        code = -1;
        irq  = stat[3] && ((pend & en) != 3'b000);
        for (int i = 0; i < 3; i++) begin
            if (code < 0 && pend[prioBit[i]] && en[prioBit[i]]) code = prioCode[i];
        end
        busy     = 0;
        expGnt   = 1'b0;
        expStall = 1'b1;
        if (exc || irq) begin
            pushExp(t + 1, 1'b0, 12'h341, tpc & ~32'd3);
            pushExp(t + 2, 1'b0, 12'h342, exc ? {27'd0, cause} : (32'h8000_0000 | 32'(code)));
            pushExp(t + 3, 1'b0, 12'h343, exc ? tval : 32'd0);
            s = (stat & ~32'h1888) | (((stat >> 3) & 32'd1) << 7) | 32'h1800;
            pushExp(t + 4, 1'b0, 12'h300, s);
            tgt = tvec & ~32'd3;
`ifdef CSR_TRAP_VECTORED_EN
            if (!exc && tvec[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
`endif
            pushExp(t + 5, 1'b1, 12'h000, tgt);
            busy = 5;
        end else if (mret) begin
            s = (stat & ~32'h1888) | (((stat >> 7) & 32'd1) << 3) | 32'h1880;
            pushExp(t + 1, 1'b0, 12'h300, s);
            pushExp(t + 2, 1'b1, 12'h000, epc);
            busy = 2;
        end else begin
            expStall = 1'b0;
            if (req) begin
                expGnt = 1'b1;
                pushExp(t, 1'b0, addr, wdata);
            end
        end
    endtask

    // Busy cycles carry random request noise that must be ignored.
    task automatic waitBusy(input int busy);
        for (int i = 0; i < busy; i++) begin
            @(posedge clk);
            #1;
            bus.exc_req         = 1'($urandom_range(0, 1));
            bus.mret_req        = 1'($urandom_range(0, 1));
            bus.instr_csr_req   = 1'($urandom_range(0, 1));
            bus.irq_pending     = 3'($urandom);
            bus.trap_pc         = $urandom;
            bus.exc_tval        = $urandom;
            bus.exc_cause       = 5'($urandom);
            bus.instr_csr_addr  = 12'($urandom);
            bus.instr_csr_wdata = $urandom;
            expGnt   = 1'b0;
            expStall = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.exc_req       = 1'b0;
        bus.mret_req      = 1'b0;
        bus.instr_csr_req = 1'b0;
        bus.irq_pending   = 3'b000;
        expGnt   = 1'b0;
        expStall = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, bus.instr_csr_gnt, 0);
        checkOutput({tag, "_we"}, bus.csr_we, 0);
        checkOutput({tag, "_waddr"}, bus.csr_waddr, 0);
        checkOutput({tag, "_wdata"}, bus.csr_wdata, 0);
        checkOutput({tag, "_stall"}, bus.stall, 0);
        checkOutput({tag, "_rv"}, bus.redirect_valid, 0);
        checkOutput({tag, "_rpc"}, bus.redirect_pc, 0);
    endtask

    initial begin
        int busy;
        bus.exc_req = 1'b0; bus.mret_req = 1'b0; bus.instr_csr_req = 1'b0;
        bus.irq_pending = '0; bus.mie_en = '0; bus.mstatus = '0; bus.mtvec = '0;
        bus.mepc = '0; bus.trap_pc = '0; bus.exc_tval = '0; bus.exc_cause = '0;
        bus.instr_csr_addr = '0; bus.instr_csr_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        monOn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 1, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
                      12'h305, 32'h8000_0100, busy);
        waitBusy(busy);
        applyStimulus(1, 0, 0, 3'b000, 3'b000, 32'h8, 32'h200, 32'h0, 32'h100, 32'hDEAD_BEEF, 5'd2,
                      12'h000, 32'h0, busy);
        waitBusy(busy);
        applyStimulus(0, 0, 0, 3'b110, 3'b111, 32'h8, 32'h201, 32'h0, 32'h400, 32'h1234, 5'd9,
                      12'h000, 32'h0, busy);
        waitBusy(busy);
        applyStimulus(0, 1, 0, 3'b000, 3'b000, 32'h1880, 32'h200, 32'h104, 32'h0, 32'h0, 5'd0,
                      12'h000, 32'h0, busy);
        waitBusy(busy);
        applyStimulus(1, 1, 1, 3'b000, 3'b000, 32'h8, 32'h300, 32'h500, 32'h182, 32'h55, 5'd4,
                      12'h305, 32'h1, busy);
        waitBusy(busy);

        // Reset lands while the mcause write is on the port.
        applyStimulus(1, 0, 0, 3'b000, 3'b000, 32'h8, 32'h600, 32'h0, 32'h700, 32'hAA, 5'd5,
                      12'h000, 32'h0, busy);
        @(posedge clk);
        #1;
        bus.exc_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        sbq.delete();
        expStall = 1'b0;
        expGnt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        for (int n = 0; n < 200; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                          $urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                          12'($urandom), $urandom, busy);
            waitBusy(busy);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sbq.size(), 0);
        monOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET return against the single write port of the `csr` register file.
- Arbitrates that write port between the pipeline's CSR-instruction path and the trap hardware.
- Sits between decode/execute, the interrupt sources and `csr`. Drives the pipeline stall and PC-redirect signals.

Parameters:
- XLEN, 32, data and PC width.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- instr_csr_req  in  1  pipeline CSR-instruction write request.
- instr_csr_addr  in  12  target CSR address.
- instr_csr_wdata  in  XLEN  write data.
- instr_csr_gnt  out  1  request granted this cycle.
- exc_req  in  1  synchronous exception, one-cycle pulse.
- exc_cause  in  5  exception code.
- exc_tval  in  XLEN  faulting address or instruction.
- trap_pc  in  XLEN  PC to save: faulting instruction for exceptions, next instruction for interrupts.
- mret_req  in  1  MRET retiring, one-cycle pulse.
- irq_pending  in  3  {meip, mtip, msip}, level-sensitive.
- mie_en  in  3  {MEIE, MTIE, MSIE} from `csr`.
- mstatus  in  XLEN  current mstatus from `csr`.
- mtvec  in  XLEN  current mtvec.
- mepc  in  XLEN  current mepc.
- csr_we  out  1  write strobe to `csr`.
- csr_waddr  out  12  write address.
- csr_wdata  out  XLEN  write data.
- stall  out  1  pipeline hold.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset: state IDLE and all outputs 0. Applies asynchronously at any point; a sequence in flight is abandoned and no further writes are issued.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_STAT, REDIR.
- Interrupt taken when `|(irq_pending & mie_en) & mstatus[3]`.
- Interrupt priority: meip (code 11) > msip (3) > mtip (7).
- IDLE arbitration, evaluated each cycle: exc_req > interrupt > mret_req > instr_csr_req.
  - Trap accepted: capture cause, tval and trap_pc; next state T_EPC.
  - Trap cause: `{1'b1, 26'b0, code}` for interrupts; `{27'b0, exc_cause}` for exceptions.
  - Trap tval: exc_tval for exceptions; 0 for interrupts.
  - MRET accepted: next state M_STAT.
  - Otherwise, if instr_csr_req: instr_csr_gnt=1 and csr_we/addr/wdata pass through combinationally in the same cycle.
  - instr_csr_gnt is 0 in every non-IDLE state and in any IDLE cycle where a trap or MRET is accepted.
- Trap sequence, one state per cycle, csr_we=1 in each:
  - T_EPC: write 0x341 with `{trap_pc[31:2], 2'b00}`.
  - T_CAUSE: write 0x342 with the captured cause.
  - T_TVAL: write 0x343 with the captured tval.
  - T_STAT: write 0x300 with mstatus where MPIE←MIE, MIE←0, MPP[12:11]←2'b11.
  - Then REDIR.
- MRET sequence:
  - M_STAT: write 0x300 with MIE←MPIE, MPIE←1, MPP←2'b11.
  - Then REDIR with target mepc.
- REDIR: redirect_valid=1 for exactly one cycle, csr_we=0; next state IDLE.
- Trap target: `{mtvec[31:2], 2'b00}`.
- Latency: trap accepted in cycle T → writes in T+1..T+4, redirect at T+5, IDLE at T+6. MRET accepted in T → write at T+1, redirect at T+2.
- stall = (state != IDLE) | trap/MRET accepted this cycle.
- Boundaries:
  - exc_req, mret_req and interrupts arriving while not IDLE are ignored. Pulses are lost; the pipeline is stalled and must not issue them.
  - Interrupts are level-sensitive and are re-sampled on return to IDLE.
  - mstatus.MIE is cleared in T_STAT, so a still-pending interrupt is not retaken until software sets MIE.
  - exc_req and mret_req in the same cycle: exception taken, MRET dropped.

Optional Feature:
- Macro: CSR_TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the trap is an interrupt, trap target = `{mtvec[31:2], 2'b00} + 4*code`. Exceptions always use the base.
- Undefined: mtvec[1:0] ignored; all traps go to the base.

Test Plan:
- Reset, then instr_csr_req writing addr 0x305, data 0x8000_0100 → same-cycle gnt=1, csr_we=1, waddr=0x305, wdata=0x8000_0100; stall=0.
- exc_req pulse with cause 2, tval 0xDEAD_BEEF, trap_pc 0x100, mstatus=0x8, mtvec=0x200 → writes mepc=0x100, mcause=2, mtval=0xDEADBEEF, mstatus=0x1880 on consecutive cycles; redirect_pc=0x200 at T+5; stall high T..T+5.
- meip and mtip both pending and enabled, MIE=1, mtvec=0x201 → mcause=0x8000_000B, mtval=0. Redirect 0x22C with CSR_TRAP_VECTORED_EN defined, 0x200 without.
- mret_req with mstatus=0x1880, mepc=0x104 → mstatus write 0x1888 at T+1, redirect_pc=0x104 at T+2.
- exc_req, mret_req and instr_csr_req all in the same cycle → exception sequence only; gnt=0.
- rst asserted during T_CAUSE → all outputs 0 immediately; no T_TVAL or T_STAT write after release.
